// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner with press and release debouncing.
// Emits the held digit (0-9) on key, NOKEY otherwise; '*' and '#' are ignored.
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 8,
    parameter int NOKEY        = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [2:0] col,
    output logic [3:0] key,
    output logic       key_valid
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_CNT);
    localparam logic [3:0]    NOKEY_CODE = 4'(NOKEY);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t        state, state_next;
    logic [3:0]    row_meta, row_s;
    logic [PW-1:0] prescaler;
    logic          tick;
    logic [CW-1:0] cnt, cnt_next, cnt_inc;
    logic [3:0]    cand, cand_next, key_next;
    logic          valid_next, advance;
    logic [1:0]    col_idx;
    logic [3:0]    code;
    logic          is_digit, match, all_high;

    assign tick     = (prescaler == PRE_LAST);
    assign all_high = (row_s == 4'b1111);
    assign match    = is_digit && (code == cand);
    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

    always_comb begin
        case (col)
            3'b101:  col_idx = 2'd1;
            3'b011:  col_idx = 2'd2;
            default: col_idx = 2'd0;
        endcase
    end

    // Lowest low row wins; row 3 only yields a digit in the middle column ('0').
    always_comb begin
        code     = NOKEY_CODE;
        is_digit = 1'b0;
        if (!row_s[0]) begin
            code     = {2'b00, col_idx} + 4'd1;
            is_digit = 1'b1;
        end else if (!row_s[1]) begin
            code     = {2'b00, col_idx} + 4'd4;
            is_digit = 1'b1;
        end else if (!row_s[2]) begin
            code     = {2'b00, col_idx} + 4'd7;
            is_digit = 1'b1;
        end else if (!row_s[3] && col_idx == 2'd1) begin
            code     = 4'd0;
            is_digit = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            row_meta  <= 4'b1111;
            row_s     <= 4'b1111;
            prescaler <= '0;
            cnt       <= '0;
            cand      <= NOKEY_CODE;
            key       <= NOKEY_CODE;
            key_valid <= 1'b0;
            col       <= 3'b110;
        end else begin
            state     <= state_next;
            row_meta  <= row;
            row_s     <= row_meta;
            prescaler <= tick ? '0 : prescaler + PW'(1);
            cnt       <= cnt_next;
            cand      <= cand_next;
            key       <= key_next;
            key_valid <= valid_next;
            if (advance)
                col <= {col[1:0], col[2]};
        end
    end

    always_comb begin
        state_next = state;
        if (tick) begin
            case (state)
                SCAN:     if (is_digit) state_next = DEBOUNCE;
                DEBOUNCE: begin
                    if (!match)
                        state_next = SCAN;
                    else if (cnt == CNT_LAST)
                        state_next = PRESSED;
                end
                PRESSED:  if (all_high) state_next = RELEASE;
                RELEASE: begin
                    if (!all_high)
                        state_next = PRESSED;
                    else if (cnt == CNT_LAST)
                        state_next = SCAN;
                end
                default:  state_next = SCAN;
            endcase
        end
    end

    // Datapath updates: column rotation, debounce count, candidate and key outputs.
    always_comb begin
        advance    = 1'b0;
        cnt_next   = cnt;
        cand_next  = cand;
        key_next   = key;
        valid_next = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (is_digit) begin
                        cand_next = code;
                        cnt_next  = CW'(1);
                    end else begin
                        advance = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (!match) begin
                        advance = 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        cnt_next   = cnt_inc;
                        key_next   = cand;
                        valid_next = 1'b1;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                PRESSED: begin
                    if (all_high)
                        cnt_next = CW'(1);
                end
                RELEASE: begin
                    if (all_high) begin
                        cnt_next = cnt_inc;
                        if (cnt == CNT_LAST) begin
                            key_next = NOKEY_CODE;
                            advance  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
